// File: rtl/roulette_wheel_spinner.sv
// Roulette spin generator: free-running LFSR picks the pocket on the spin press, the wheel
// animates with a decelerating step rate, then the result is held under a valid/ack handshake.
module roulette_wheel_spinner #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          BASE_DIV   = 2,
    parameter int          SLOWDOWN   = 1,
    parameter int          SPIN_STEPS = 4
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       spin_req,
    input  logic       result_ack,
    output logic [4:0] randnum,
    output logic       result_valid,
    output logic [4:0] wheel_pos,
    output logic       busy
);
    localparam logic [15:0] SEED_OK       = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] BASE          = 16'(BASE_DIV);
    localparam logic [15:0] SLOW          = 16'(SLOWDOWN);
    localparam logic [7:0]  STEPS         = 8'(SPIN_STEPS);
    localparam logic [15:0] SETTLE_RELOAD = 16'(BASE_DIV + SPIN_STEPS * SLOWDOWN - 1);

    typedef enum logic [1:0] {IDLE, SPIN, SETTLE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [15:0] div_cnt, div_cnt_nxt;
    logic [7:0]  step_cnt, step_cnt_nxt, step_new;
    logic [4:0]  target, target_nxt, wheel_nxt, randnum_nxt;
    logic        valid_nxt, spin_req_d, spin_edge, step;

    assign spin_edge = spin_req & ~spin_req_d;
    assign busy      = (state != IDLE);
    assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    assign step_new  = ((state == IDLE) ? 8'd0 : step_cnt) + 8'd1;

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        step_cnt_nxt = step_cnt;
        target_nxt   = target;
        wheel_nxt    = wheel_pos;
        randnum_nxt  = randnum;
        valid_nxt    = result_valid;
        step         = 1'b0;
        case (state)
            IDLE: begin
                if (spin_edge) begin
                    target_nxt   = lfsr[4:0];
                    step_cnt_nxt = 8'd0;
                    state_nxt    = SPIN;
                    // The press cycle itself is the first cycle of the first step interval.
                    if (BASE == 16'd1) step = 1'b1;
                    else               div_cnt_nxt = BASE - 16'd2;
                end
            end
            SPIN: begin
                if (div_cnt == 16'd0) step = 1'b1;
                else                  div_cnt_nxt = div_cnt - 16'd1;
            end
            SETTLE: begin
                if (wheel_pos == target) begin
                    state_nxt   = HOLD;
                    randnum_nxt = target;
                    valid_nxt   = 1'b1;
                end else if (div_cnt == 16'd0) begin
                    wheel_nxt   = wheel_pos + 5'd1;
                    div_cnt_nxt = SETTLE_RELOAD;
                end else begin
                    div_cnt_nxt = div_cnt - 16'd1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Decelerating phase: each completed step lengthens the next interval.
        if (step) begin
            wheel_nxt    = wheel_pos + 5'd1;
            step_cnt_nxt = step_new;
            div_cnt_nxt  = BASE + {8'd0, step_new} * SLOW - 16'd1;
            if (step_new == STEPS) state_nxt = SETTLE;
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lfsr         <= SEED_OK;
            spin_req_d   <= 1'b0;
            div_cnt      <= 16'd0;
            step_cnt     <= 8'd0;
            target       <= 5'd0;
            wheel_pos    <= 5'd0;
            randnum      <= 5'd0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            lfsr         <= lfsr_nxt;
            spin_req_d   <= spin_req;
            div_cnt      <= div_cnt_nxt;
            step_cnt     <= step_cnt_nxt;
            target       <= target_nxt;
            wheel_pos    <= wheel_nxt;
            randnum      <= randnum_nxt;
            result_valid <= valid_nxt;
        end
    end
endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Bench for roulette_wheel_spinner: each spin's step schedule is derived from the interval
// rules and compared cycle by cycle against the wheel, busy, valid and result outputs.
module tb_roulette_wheel_spinner;
    localparam int B = 2;
    localparam int S = 1;
    localparam int N_STEPS = 4;

    logic       Clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       spin_req = 1'b0;
    logic       result_ack = 1'b0;
    logic [4:0] randnum;
    logic       result_valid;
    logic [4:0] wheel_pos;
    logic       busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    int          exp_wheel = 0;
    int          exp_rand = 0;

    roulette_wheel_spinner #(
        .SEED(16'hACE1), .BASE_DIV(B), .SLOWDOWN(S), .SPIN_STEPS(N_STEPS)
    ) dut (
        .Clock(Clock), .reset_n(reset_n), .spin_req(spin_req), .result_ack(result_ack),
        .randnum(randnum), .result_valid(result_valid), .wheel_pos(wheel_pos), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Pocket source: the LFSR value present in each clock period.
    always @(posedge Clock or negedge reset_n) begin
        if (!reset_n) m_lfsr = 16'hACE1;
        else          m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_valid"}, 32'(result_valid), 32'(0));
        chk({tag, "_wheel"}, 32'(wheel_pos), 32'(exp_wheel));
        chk({tag, "_rand"}, 32'(randnum), 32'(exp_rand));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            @(negedge Clock);
            chk_idle("idle");
        end
    endtask

    // want<0: spin at the next cycle; otherwise wait for the cycle whose pocket equals want.
    task automatic run_spin(input int want, input int ack_wait, input bit ack_early,
                            input bit extra, input bit hold_req);
        bit found = 0;
        int tgt, p0, p, t, v, m, nsteps;
        int steps_at[$];
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge Clock); #1;
            if (want < 0 || int'(m_lfsr[4:0]) == want) found = 1;
            else begin
                @(negedge Clock);
                chk_idle("wait");
            end
        end
        chk("find_target", 32'(found), 32'(1));
        if (!found) return;
        tgt = int'(m_lfsr[4:0]);
        p0  = exp_wheel;
        p   = p0;
        t   = 0;
        for (int k = 0; k < N_STEPS; k++) begin
            t += B + k * S;
            steps_at.push_back(t);
            p = (p + 1) % 32;
        end
        while (p != tgt) begin
            t += B + N_STEPS * S;
            steps_at.push_back(t);
            p = (p + 1) % 32;
        end
        v = t + 1;
        m = ack_early ? v : v + ack_wait;
        for (int c = 0; c <= m + 3; c++) begin
            if (c > 0) begin
                @(posedge Clock); #1;
            end
            spin_req   = hold_req ? 1'b1
                       : (c == 0 || (extra && (c == 5 || (c == v + 2 && c < m))));
            result_ack = ack_early ? (c >= 1 && c <= m) : (c == m);
            @(negedge Clock);
            nsteps = 0;
            foreach (steps_at[i]) if (steps_at[i] <= c) nsteps++;
            chk("spin_wheel", 32'(wheel_pos), 32'((p0 + nsteps) % 32));
            chk("spin_busy", 32'(busy), 32'(c >= 1 && c <= m));
            chk("spin_valid", 32'(result_valid), 32'(c >= v && c <= m));
            chk("spin_rand", 32'(randnum), 32'(c >= v ? tgt : exp_rand));
        end
        result_ack = 1'b0;
        exp_wheel  = p;
        exp_rand   = tgt;
        if (hold_req) begin
            idle(10);
            spin_req = 1'b0;
        end
    endtask

    task automatic reset_mid_spin();
        @(posedge Clock); #1;
        spin_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Clock); #1;
            spin_req = 1'b0;
            @(negedge Clock);
            chk("mid_busy", 32'(busy), 32'(1));
        end
        @(posedge Clock); #3;
        reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_wheel", 32'(wheel_pos), 32'(0));
        chk("async_rand", 32'(randnum), 32'(0));
        chk("async_valid", 32'(result_valid), 32'(0));
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        reset_n   = 1'b1;
        exp_wheel = 0;
        exp_rand  = 0;
        idle(20);
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        reset_n = 1'b1;
        chk_idle("reset");
        idle(20);

        // Target behind the wheel: settle wraps 5..31,0,1,2.
        run_spin(2, 3, 0, 0, 0);
        chk("wrap_rand", 32'(randnum), 32'(2));
        idle(3);
        run_spin(-1, 2, 0, 0, 0);
        idle(5);
        run_spin(-1, 50, 0, 1, 0);
        idle(4);
        run_spin(-1, 0, 1, 0, 0);
        idle(2);
        run_spin(-1, 4, 0, 0, 1);
        idle(2);
        for (int r = 0; r < 8; r++) begin
            idle(int'($urandom_range(0, 40)));
            run_spin(-1, int'($urandom_range(0, 10)), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), 1'b0);
        end
        reset_mid_spin();
        run_spin(-1, 1, 0, 0, 0);
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
